wta_bus_src_mux_buf: RTL and testbench
======================================

// Module: wta_bus_src_mux_buf
// PURPOSE
//   Parametrised successor to the write-to-accumulator bus source select.
//   Selects one of NUM_SRC register sources by io_sel and captures it on a valid/ready request.
//   Buffers the captured word in a 2-entry FIFO skid buffer and presents it downstream with valid/ready.
//   Sits between the core register file/special registers and the datapath bus input.
// PARAMETERS
//   WIDTH    16  data width of every source and of io_muxOut
//   NUM_SRC  15  number of selectable sources (1..2**SEL_W)
//   SEL_W    4   width of io_sel
// PORTS
//   clock        in   1              single clock, rising edge
//   reset        in   1              asynchronous, active-high
//   io_en        in   1              request valid: capture source io_sel this cycle
//   io_sel       in   SEL_W          source index
//   io_reqReady  out  1              buffer can accept a request
//   io_src       in   NUM_SRC*WIDTH  flat sources; source k at [k*WIDTH +: WIDTH]
//   io_outValid  out  1              io_muxOut/io_outErr hold a buffered word
//   io_outReady  in   1              downstream accepts the head word
//   io_muxOut    out  WIDTH          head data
//   io_outErr    out  1              head word came from an out-of-range io_sel
//   io_muxParity out  1              even parity of io_muxOut (WTA_MUX_PARITY_EN only)
// BEHAVIOUR
//   - Reset: clock and reset are fixed as above; reset acts immediately, not at the next edge.
//     - FIFO count=0; io_outValid=0, io_muxOut=0, io_outErr=0, io_muxParity=0.
//     - io_reqReady=1 while count<2, including during reset.
//   - Push: io_en && io_reqReady at the rising edge.
//     - Sample io_src[io_sel*WIDTH +: WIDTH] at that edge.
//     - Later source changes never affect a buffered word.
//   - Pop: io_outValid && io_outReady at the rising edge.
//   - Latency: a push into an empty FIFO shows io_outValid=1 with the data on the next cycle.
//     - There is no combinational path from io_src to io_muxOut.
//   - Ordering: strict FIFO. Head = oldest word; io_muxOut, io_outErr and io_muxParity all describe the head.
//   - Count rules:
//     - push only: +1.
//     - pop only: -1.
//     - push+pop at count 1: count stays 1, new word becomes head next cycle.
//     - push+pop at count 0: impossible, because io_outValid=0.
//   - Full (count=2): io_reqReady=0; io_en is ignored; sources are not sampled. io_reqReady depends only on count.
//   - Empty: io_outValid=0; io_muxOut and io_outErr hold the last popped values. Downstream must not use them.
//   - io_sel >= NUM_SRC: push a word with data=0 and err=1. It is never dropped.
//   - io_en=0: no capture; buffered contents hold indefinitely.
//   - Reset mid-operation: all buffered words are discarded; no partial output.
// CONFIGURATION
//   WTA_MUX_PARITY_EN defined:
//     - Each entry stores a parity bit, ^data computed at push. It is driven on io_muxParity.
//     - err entries carry parity 0.
//   WTA_MUX_PARITY_EN undefined:
//     - No parity storage; io_muxParity is tied to 0. The port is kept for a stable interface.
// STRUCTURE
//   - Package wta_mux_pkg holds:
//     - WTA_WIDTH=16, WTA_NUM_SRC=15, WTA_SEL_W=4.
//     - Source index constants: SRC_N=0, SRC_M=1, SRC_P=2, SRC_R1=3, SRC_ROW=4, SRC_COL=5,
//       SRC_CURR=6, SRC_SUM=7, SRC_STA=8, SRC_STB=9, SRC_STC=10, SRC_A=11, SRC_B=12,
//       SRC_R=13, SRC_COREID=14.
//     - Typedef wta_entry_t {data, err, par}.
//   - Sub-module wta_skid_fifo2: generic 2-entry valid/ready FIFO of wta_entry_t.
//   - The top module holds only the selection, range check and parity logic.
// TESTING
//   Default sources: N=31, M=22, P=43, R1=24, ROW=25, COL=16, CURR=27, SUM=38, STA=439,
//   STB=10, STC=11, A=12, B=13, R=14, CoreID=15.
//   1. io_outReady=1, io_en=1; io_sel 0,1,2,5,4,7,3,8,9,10,13 on consecutive cycles.
//      -> io_muxOut one cycle later: 31,22,43,16,25,38,24,439,10,11,14; io_outErr=0.
//   2. io_outReady=0; push sel=0, then sel=14, then sel=2.
//      -> io_reqReady=0 after 2 pushes; third push ignored.
//      -> raise io_outReady: outputs 31 then 15, then io_outValid=0.
//   3. io_sel=15 with io_en=1 -> next cycle io_muxOut=0, io_outErr=1.
//      Then sel=11 -> io_muxOut=12, io_outErr=0.
//   4. Push sel=8, then change STA to 7 before the pop -> popped value 439.
//   5. FIFO holding 2 words; assert reset for half a cycle.
//      -> io_outValid=0 and io_reqReady=1 immediately; no stale word after release.
//   6. WTA_MUX_PARITY_EN defined: sel=8 (439=0x1B7) -> io_muxParity=1; sel=1 (22) -> 1; sel=11 (12) -> 0.

Source files
------------

// File: rtl/wta_bus_src_mux_buf_pkg.sv
// Shared constants and entry type for the accumulator-bus source mux and its skid FIFO.
// The parity feature is enabled by defining WTA_MUX_PARITY_EN.
package wta_mux_pkg;

  localparam int WTA_WIDTH   = 16;
  localparam int WTA_NUM_SRC = 15;
  localparam int WTA_SEL_W   = 4;

  // Source slot numbers as seen on io_sel
  localparam int SRC_N      = 0;
  localparam int SRC_M      = 1;
  localparam int SRC_P      = 2;
  localparam int SRC_R1     = 3;
  localparam int SRC_ROW    = 4;
  localparam int SRC_COL    = 5;
  localparam int SRC_CURR   = 6;
  localparam int SRC_SUM    = 7;
  localparam int SRC_STA    = 8;
  localparam int SRC_STB    = 9;
  localparam int SRC_STC    = 10;
  localparam int SRC_A      = 11;
  localparam int SRC_B      = 12;
  localparam int SRC_R      = 13;
  localparam int SRC_COREID = 14;

  typedef struct packed {
    logic [WTA_WIDTH-1:0] data;
    logic                 err;
    logic                 par;
  } wta_entry_t;

endpackage

// File: rtl/wta_bus_src_mux_buf_if.sv
// Request/response bundle between the register-file side (master) and the source mux buffer (slave).
// The parity line is always present; it is only meaningful when WTA_MUX_PARITY_EN is defined.
interface wta_bus_src_mux_buf_if
  import wta_mux_pkg::*;
#(
  parameter int WIDTH   = WTA_WIDTH,
  parameter int NUM_SRC = WTA_NUM_SRC,
  parameter int SEL_W   = WTA_SEL_W
);

  logic                     io_en;
  logic [SEL_W-1:0]         io_sel;
  logic                     io_reqReady;
  logic [NUM_SRC*WIDTH-1:0] io_src;
  logic                     io_outValid;
  logic                     io_outReady;
  logic [WIDTH-1:0]         io_muxOut;
  logic                     io_outErr;
  logic                     io_muxParity;

  modport master (
    output io_en, io_sel, io_src, io_outReady,
    input  io_reqReady, io_outValid, io_muxOut, io_outErr, io_muxParity
  );

  modport slave (
    input  io_en, io_sel, io_src, io_outReady,
    output io_reqReady, io_outValid, io_muxOut, io_outErr, io_muxParity
  );

endinterface

// File: rtl/wta_bus_src_mux_buf_skid_fifo2.sv
// Two-entry valid/ready FIFO kept as a head/tail shift pair so the head register drives the output
// directly and keeps the last popped word when the FIFO drains.
module wta_skid_fifo2
  import wta_mux_pkg::*;
#(
  parameter type entry_t = wta_entry_t
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   in_valid_i,
  output logic   in_ready_o,
  input  entry_t in_data_i,
  output logic   out_valid_o,
  input  logic   out_ready_i,
  output entry_t out_data_o
);

  logic [1:0] count_q, count_d;
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic       push;
  logic       pop;

  // Ready depends on occupancy only, never on in_valid_i
  assign in_ready_o  = (count_q != 2'd2);
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({push, pop})
      2'b10: begin
        count_d = count_q + 2'd1;
        if (count_q == 2'd0) begin
          head_d = in_data_i;
        end else begin
          tail_d = in_data_i;
        end
      end
      2'b01: begin
        count_d = count_q - 2'd1;
        if (count_q == 2'd2) begin
          head_d = tail_q;
        end
      end
      // Simultaneous push and pop can only happen with one word held
      2'b11: head_d = in_data_i;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/wta_bus_src_mux_buf.sv
// Accumulator-bus source select: picks one of NUM_SRC sources, tags out-of-range selects, buffers in a
// 2-entry skid FIFO. Optional per-entry even parity when WTA_MUX_PARITY_EN is defined.
module wta_bus_src_mux_buf
  import wta_mux_pkg::*;
#(
  parameter int WIDTH   = WTA_WIDTH,
  parameter int NUM_SRC = WTA_NUM_SRC,
  parameter int SEL_W   = WTA_SEL_W
) (
  input logic                  clock,
  input logic                  reset,
  wta_bus_src_mux_buf_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
    logic             par;
  } buf_entry_t;

  logic [WIDTH-1:0] src_arr [NUM_SRC];
  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;
  buf_entry_t       push_entry;
  buf_entry_t       head_entry;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_arr[gi] = bus.io_src[gi*WIDTH +: WIDTH];
  end

  // Out-of-range selects fall through with zero data and no hit
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.io_sel == SEL_W'(k)) begin
        sel_data = src_arr[k];
        sel_hit  = 1'b1;
      end
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.data = sel_data;
    push_entry.err  = ~sel_hit;
`ifdef WTA_MUX_PARITY_EN
    push_entry.par  = sel_hit & (^sel_data);
`endif
  end

  wta_skid_fifo2 #(
    .entry_t (buf_entry_t)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (bus.io_en),
    .in_ready_o  (bus.io_reqReady),
    .in_data_i   (push_entry),
    .out_valid_o (bus.io_outValid),
    .out_ready_i (bus.io_outReady),
    .out_data_o  (head_entry)
  );

  assign bus.io_muxOut = head_entry.data;
  assign bus.io_outErr = head_entry.err;

`ifdef WTA_MUX_PARITY_EN
  assign bus.io_muxParity = head_entry.par;
`else
  logic unused_par;
  assign unused_par       = head_entry.par;
  assign bus.io_muxParity = 1'b0;
`endif

endmodule

// File: tb/tb_wta_bus_src_mux_buf.sv
// Directed bench for the accumulator-bus source mux buffer; one task per scenario.
module tb_wta_bus_src_mux_buf;
  import wta_mux_pkg::*;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  wta_bus_src_mux_buf_if bus_if ();

  wta_bus_src_mux_buf dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_src(input int k, input int val);
    bus_if.io_src[k*16 +: 16] = val[15:0];
  endtask

  task automatic load_defaults();
    int dflt [15] = '{31, 22, 43, 24, 25, 16, 27, 38, 439, 10, 11, 12, 13, 14, 15};
    for (int k = 0; k < 15; k++) set_src(k, dflt[k]);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.io_en = 1'b0;
    bus_if.io_sel = '0;
    bus_if.io_outReady = 1'b0;
    load_defaults();
    #2;
    tests_run++;
    if (bus_if.io_outValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b want 0", bus_if.io_outValid);
    end
    tests_run++;
    if (bus_if.io_reqReady !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_reqReady: got %b want 1", bus_if.io_reqReady);
    end
    tests_run++;
    if ({bus_if.io_muxOut, bus_if.io_outErr, bus_if.io_muxParity} !== 18'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got out=%0d err=%b par=%b want 0/0/0",
               bus_if.io_muxOut, bus_if.io_outErr, bus_if.io_muxParity);
    end
    step();
    step();
    @(negedge clock);
    reset = 1'b0;
    step();
    $display("[TB] test_reset done");
  endtask

  task automatic test_stream();
    int sels [11] = '{0, 1, 2, 5, 4, 7, 3, 8, 9, 10, 13};
    int exps [11] = '{31, 22, 43, 16, 25, 38, 24, 439, 10, 11, 14};
    bus_if.io_outReady = 1'b1;
    bus_if.io_en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus_if.io_sel = sels[i][3:0];
      step();
      tests_run++;
      if (bus_if.io_outValid !== 1'b1 || bus_if.io_muxOut !== exps[i][15:0] || bus_if.io_outErr !== 1'b0) begin
        tests_failed++;
        $display("FAIL stream_sel%0d: got v=%b out=%0d err=%b want v=1 out=%0d err=0",
                 sels[i], bus_if.io_outValid, bus_if.io_muxOut, bus_if.io_outErr, exps[i]);
      end
      $display("[TB] stream sel=%0d out=%0d", sels[i], bus_if.io_muxOut);
    end
    bus_if.io_en = 1'b0;
    step();
    tests_run++;
    if (bus_if.io_outValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_drain: got v=%b want 0", bus_if.io_outValid);
    end
  endtask

  task automatic test_full();
    bus_if.io_outReady = 1'b0;
    bus_if.io_en = 1'b1;
    bus_if.io_sel = 4'd0;
    step();
    bus_if.io_sel = 4'd14;
    step();
    tests_run++;
    if (bus_if.io_reqReady !== 1'b0 || bus_if.io_muxOut !== 16'd31) begin
      tests_failed++;
      $display("FAIL full_after2: got rdy=%b out=%0d want rdy=0 out=31", bus_if.io_reqReady, bus_if.io_muxOut);
    end
    bus_if.io_sel = 4'd2;
    step();
    tests_run++;
    if (bus_if.io_reqReady !== 1'b0 || bus_if.io_muxOut !== 16'd31 || bus_if.io_outValid !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_ignore: got rdy=%b v=%b out=%0d want rdy=0 v=1 out=31",
               bus_if.io_reqReady, bus_if.io_outValid, bus_if.io_muxOut);
    end
    bus_if.io_en = 1'b0;
    bus_if.io_outReady = 1'b1;
    step();
    tests_run++;
    if (bus_if.io_muxOut !== 16'd15 || bus_if.io_outValid !== 1'b1 || bus_if.io_reqReady !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_pop1: got v=%b out=%0d rdy=%b want v=1 out=15 rdy=1",
               bus_if.io_outValid, bus_if.io_muxOut, bus_if.io_reqReady);
    end
    step();
    tests_run++;
    if (bus_if.io_outValid !== 1'b0 || bus_if.io_muxOut !== 16'd15) begin
      tests_failed++;
      $display("FAIL full_empty: got v=%b out=%0d want v=0 out=15 (held)", bus_if.io_outValid, bus_if.io_muxOut);
    end
    $display("[TB] test_full done");
  endtask

  task automatic test_out_of_range();
    bus_if.io_outReady = 1'b1;
    bus_if.io_en = 1'b1;
    bus_if.io_sel = 4'd15;
    step();
    tests_run++;
    if (bus_if.io_outValid !== 1'b1 || bus_if.io_muxOut !== 16'd0 || bus_if.io_outErr !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_sel15: got v=%b out=%0d err=%b want v=1 out=0 err=1",
               bus_if.io_outValid, bus_if.io_muxOut, bus_if.io_outErr);
    end
    bus_if.io_sel = 4'd11;
    step();
    tests_run++;
    if (bus_if.io_muxOut !== 16'd12 || bus_if.io_outErr !== 1'b0) begin
      tests_failed++;
      $display("FAIL oor_then11: got out=%0d err=%b want out=12 err=0", bus_if.io_muxOut, bus_if.io_outErr);
    end
    bus_if.io_en = 1'b0;
    step();
    $display("[TB] test_out_of_range done");
  endtask

  task automatic test_source_isolation();
    bus_if.io_outReady = 1'b0;
    bus_if.io_en = 1'b1;
    bus_if.io_sel = SRC_STA[3:0];
    step();
    bus_if.io_en = 1'b0;
    set_src(SRC_STA, 7);
    step();
    tests_run++;
    if (bus_if.io_muxOut !== 16'd439 || bus_if.io_outValid !== 1'b1) begin
      tests_failed++;
      $display("FAIL isolate_sta: got v=%b out=%0d want v=1 out=439", bus_if.io_outValid, bus_if.io_muxOut);
    end
    bus_if.io_outReady = 1'b1;
    step();
    tests_run++;
    if (bus_if.io_outValid !== 1'b0) begin
      tests_failed++;
      $display("FAIL isolate_pop: got v=%b want 0", bus_if.io_outValid);
    end
    set_src(SRC_STA, 439);
    $display("[TB] test_source_isolation done");
  endtask

  task automatic test_mid_reset();
    bus_if.io_outReady = 1'b0;
    bus_if.io_en = 1'b1;
    bus_if.io_sel = 4'd0;
    step();
    bus_if.io_sel = 4'd1;
    step();
    bus_if.io_en = 1'b0;
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus_if.io_outValid !== 1'b0 || bus_if.io_reqReady !== 1'b1 || bus_if.io_muxOut !== 16'd0) begin
      tests_failed++;
      $display("FAIL midrst_async: got v=%b rdy=%b out=%0d want v=0 rdy=1 out=0",
               bus_if.io_outValid, bus_if.io_reqReady, bus_if.io_muxOut);
    end
    #4;
    reset = 1'b0;
    bus_if.io_outReady = 1'b1;
    step();
    tests_run++;
    if (bus_if.io_outValid !== 1'b0 || bus_if.io_reqReady !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_after: got v=%b rdy=%b want v=0 rdy=1", bus_if.io_outValid, bus_if.io_reqReady);
    end
    $display("[TB] test_mid_reset done");
  endtask

  task automatic test_parity();
    int  sels [4] = '{8, 1, 11, 15};
`ifdef WTA_MUX_PARITY_EN
    logic pars [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`else
    logic pars [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    bus_if.io_outReady = 1'b1;
    bus_if.io_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_if.io_sel = sels[i][3:0];
      step();
      tests_run++;
      if (bus_if.io_muxParity !== pars[i]) begin
        tests_failed++;
        $display("FAIL parity_sel%0d: got %b want %b", sels[i], bus_if.io_muxParity, pars[i]);
      end
      $display("[TB] parity sel=%0d par=%b", sels[i], bus_if.io_muxParity);
    end
    bus_if.io_en = 1'b0;
    step();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_stream();
    test_full();
    test_out_of_range();
    test_source_isolation();
    test_mid_reset();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
